// File: rtl/extra_hdr_noc_narrow_to_wide_pkg.sv
// Shared definitions for the control-to-data NoC converter: FSM states,
// routing header field positions and width helpers.
package beehive_ctrl_noc_msg;

    // msg_len lives in the first base-header flit, metadata_flits in the second
    localparam int MSG_LEN_W      = 22;
    localparam int MSG_LEN_LSB    = 8;
    localparam int META_FLITS_W   = 8;
    localparam int META_FLITS_LSB = 22;
    localparam int REM_W          = $clog2((1 << MSG_LEN_W) - 1) + 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR_2,
        EXTRA,
        HDR_OUT,
        FILL,
        DATA_OUT
    } ctd_state_e;

    function automatic int calc_ratio(input int wide_w, input int narrow_w);
        return wide_w / narrow_w;
    endfunction

    function automatic int calc_extra_flits(input int extra_w, input int narrow_w);
        return (extra_w + narrow_w - 1) / narrow_w;
    endfunction

endpackage

// File: rtl/extra_hdr_noc_narrow_to_wide_if.sv
// Narrow control-NoC input channel and wide data-NoC output channel.
interface extra_hdr_noc_narrow_to_wide_if #(
    parameter int NARROW_W = 64,
    parameter int WIDE_W   = 512
);
    logic                src_noc_ctd_val;
    logic [NARROW_W-1:0] src_noc_ctd_data;
    logic                noc_ctd_src_rdy;
    logic                noc_ctd_dst_val;
    logic [WIDE_W-1:0]   noc_ctd_dst_data;
    logic                dst_noc_ctd_rdy;

    modport master (
        output src_noc_ctd_val, src_noc_ctd_data, dst_noc_ctd_rdy,
        input  noc_ctd_src_rdy, noc_ctd_dst_val, noc_ctd_dst_data
    );

    modport slave (
        input  src_noc_ctd_val, src_noc_ctd_data, dst_noc_ctd_rdy,
        output noc_ctd_src_rdy, noc_ctd_dst_val, noc_ctd_dst_data
    );
endinterface

// File: rtl/extra_hdr_noc_narrow_to_wide_packer.sv
// Packs narrow flits MSB-first into one wide flit; unwritten slots stay zero
// after a clear.
module narrow_to_wide_packer
    import beehive_ctrl_noc_msg::*;
#(
    parameter int NARROW_W = 64,
    parameter int WIDE_W   = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                wr_en_i,
    input  logic [NARROW_W-1:0] wr_data_i,
    output logic [WIDE_W-1:0]   wide_o,
    output logic                full_o
);
    localparam int RATIO = calc_ratio(WIDE_W, NARROW_W);
    localparam int IDX_W = $clog2(RATIO + 1);

    logic [WIDE_W-1:0] wide_q, wide_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    always_comb begin
        wide_d = wide_q;
        idx_d  = idx_q;
        if (clear_i) begin
            wide_d = '0;
            idx_d  = '0;
        end else if (wr_en_i) begin
            for (int k = 0; k < RATIO; k++) begin
                if (idx_q == IDX_W'(k)) wide_d[WIDE_W-1-k*NARROW_W -: NARROW_W] = wr_data_i;
            end
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) idx_q <= '0;
        else     idx_q <= idx_d;
    end

    always_ff @(posedge clk) begin
        wide_q <= wide_d;
    end

    // Asserted with the write that completes the wide flit.
    assign full_o = wr_en_i && (idx_q == IDX_W'(RATIO - 1));
    assign wide_o = wide_q;

endmodule

// File: rtl/extra_hdr_noc_narrow_to_wide.sv
// Control-NoC to data-NoC converter: base + extra header into one wide flit,
// then narrow payload packed into wide flits. Optional EXTRA_HDR_CTD_STATS_EN.
module extra_hdr_noc_narrow_to_wide
    import beehive_ctrl_noc_msg::*;
#(
    parameter int NARROW_W = 64,
    parameter int WIDE_W   = 512,
    parameter int EXTRA_W  = 96
) (
    input  logic clk,
    input  logic rst,
    extra_hdr_noc_narrow_to_wide_if.slave ctd
`ifdef EXTRA_HDR_CTD_STATS_EN
    ,
    output logic [31:0] stat_msg_cnt,
    output logic [31:0] stat_wide_flit_cnt
`endif
);
    localparam int RATIO       = calc_ratio(WIDE_W, NARROW_W);
    localparam int EXTRA_FLITS = calc_extra_flits(EXTRA_W, NARROW_W);
    localparam int BASE_FLIT_W = 2 * NARROW_W;
    localparam int LAST_W      = EXTRA_W - (EXTRA_FLITS - 1) * NARROW_W;
    localparam int EIDX_W      = (EXTRA_FLITS > 1) ? $clog2(EXTRA_FLITS) : 1;

    ctd_state_e state_q, state_d;

    logic [NARROW_W-1:0] hdr1_q, hdr1_d, hdr2_q, hdr2_d;
    logic [EXTRA_W-1:0]  extra_q, extra_d;
    logic [EIDX_W-1:0]   eidx_q, eidx_d;
    logic [REM_W-1:0]    rem_q, rem_d;

    logic src_rdy, dst_val, src_acc, dst_acc;
    logic pk_clear, pk_wr, pk_full;
    logic [WIDE_W-1:0] pk_wide, hdr_flit;

    function automatic logic [MSG_LEN_W-1:0] ceil_div_ratio(input logic [REM_W-1:0] n);
        return MSG_LEN_W'((n + REM_W'(RATIO - 1)) / REM_W'(RATIO));
    endfunction

    function automatic logic [WIDE_W-1:0] build_hdr(
        input logic [NARROW_W-1:0] h1,
        input logic [NARROW_W-1:0] h2,
        input logic [EXTRA_W-1:0]  ex,
        input logic [REM_W-1:0]    n
    );
        logic [WIDE_W-1:0] f;
        f = '0;
        f[WIDE_W-1 -: BASE_FLIT_W]                         = {h1, h2};
        f[WIDE_W-BASE_FLIT_W-1 -: EXTRA_W]                 = ex;
        f[WIDE_W-NARROW_W+MSG_LEN_LSB +: MSG_LEN_W]        = ceil_div_ratio(n);
        f[WIDE_W-2*NARROW_W+META_FLITS_LSB +: META_FLITS_W] = '0;
        return f;
    endfunction

    assign src_acc = ctd.src_noc_ctd_val && src_rdy;
    assign dst_acc = dst_val && ctd.dst_noc_ctd_rdy;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (src_acc) state_d = HDR_2;
            HDR_2:    if (src_acc) state_d = EXTRA;
            EXTRA:    if (src_acc && eidx_q == EIDX_W'(EXTRA_FLITS - 1)) state_d = HDR_OUT;
            HDR_OUT:  if (dst_acc) state_d = (rem_q == '0) ? IDLE : FILL;
            FILL:     if (src_acc && (pk_full || rem_q == REM_W'(1))) state_d = DATA_OUT;
            DATA_OUT: if (dst_acc) state_d = (rem_q == '0) ? IDLE : FILL;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        src_rdy = 1'b0;
        dst_val = 1'b0;
        unique case (state_q)
            IDLE, HDR_2, EXTRA, FILL: src_rdy = 1'b1;
            HDR_OUT, DATA_OUT:        dst_val = 1'b1;
            default: ;
        endcase
    end

    // Header capture and payload countdown; the first extra flit lands in the MSBs
    always_comb begin
        hdr1_d  = hdr1_q;
        hdr2_d  = hdr2_q;
        extra_d = extra_q;
        eidx_d  = eidx_q;
        rem_d   = rem_q;
        if (src_acc) begin
            unique case (state_q)
                IDLE: begin
                    hdr1_d = ctd.src_noc_ctd_data;
                    rem_d  = REM_W'(ctd.src_noc_ctd_data[MSG_LEN_LSB +: MSG_LEN_W]);
                end
                HDR_2: begin
                    hdr2_d = ctd.src_noc_ctd_data;
                    eidx_d = '0;
                end
                EXTRA: begin
                    for (int k = 0; k < EXTRA_FLITS - 1; k++) begin
                        if (eidx_q == EIDX_W'(k))
                            extra_d[EXTRA_W-1-k*NARROW_W -: NARROW_W] = ctd.src_noc_ctd_data;
                    end
                    if (eidx_q == EIDX_W'(EXTRA_FLITS - 1))
                        extra_d[LAST_W-1:0] = ctd.src_noc_ctd_data[NARROW_W-1 -: LAST_W];
                    eidx_d = eidx_q + EIDX_W'(1);
                end
                FILL:    rem_d = rem_q - REM_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eidx_q <= '0;
            rem_q  <= '0;
        end else begin
            eidx_q <= eidx_d;
            rem_q  <= rem_d;
        end
    end

    always_ff @(posedge clk) begin
        hdr1_q  <= hdr1_d;
        hdr2_q  <= hdr2_d;
        extra_q <= extra_d;
    end

    assign pk_clear = dst_acc && (rem_q != '0);
    assign pk_wr    = (state_q == FILL) && src_acc;

    narrow_to_wide_packer #(
        .NARROW_W (NARROW_W),
        .WIDE_W   (WIDE_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (pk_clear),
        .wr_en_i   (pk_wr),
        .wr_data_i (ctd.src_noc_ctd_data),
        .wide_o    (pk_wide),
        .full_o    (pk_full)
    );

    // rem_q still holds the narrow payload count N while in HDR_OUT
    assign hdr_flit = build_hdr(hdr1_q, hdr2_q, extra_q, rem_q);

    assign ctd.noc_ctd_src_rdy  = src_rdy;
    assign ctd.noc_ctd_dst_val  = dst_val;
    assign ctd.noc_ctd_dst_data = (state_q == HDR_OUT) ? hdr_flit : pk_wide;

`ifdef EXTRA_HDR_CTD_STATS_EN
    logic [31:0] stat_msg_cnt_q, stat_wide_flit_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_msg_cnt_q       <= '0;
            stat_wide_flit_cnt_q <= '0;
        end else begin
            if (dst_acc && state_q == HDR_OUT) stat_msg_cnt_q <= stat_msg_cnt_q + 32'd1;
            if (dst_acc) stat_wide_flit_cnt_q <= stat_wide_flit_cnt_q + 32'd1;
        end
    end

    assign stat_msg_cnt       = stat_msg_cnt_q;
    assign stat_wide_flit_cnt = stat_wide_flit_cnt_q;
`endif

endmodule

// File: tb/tb_extra_hdr_noc_narrow_to_wide.sv
// Scoreboard bench for extra_hdr_noc_narrow_to_wide at default parameters.
module tb_extra_hdr_noc_narrow_to_wide;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    extra_hdr_noc_narrow_to_wide_if #(.NARROW_W(64), .WIDE_W(512)) bus ();

`ifdef EXTRA_HDR_CTD_STATS_EN
    logic [31:0] stat_msg_cnt, stat_wide_flit_cnt;
`endif

    extra_hdr_noc_narrow_to_wide #(
        .NARROW_W (64),
        .WIDE_W   (512),
        .EXTRA_W  (96)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctd (bus)
`ifdef EXTRA_HDR_CTD_STATS_EN
        ,
        .stat_msg_cnt       (stat_msg_cnt),
        .stat_wide_flit_cnt (stat_wide_flit_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [511:0] exp_q[$];
    logic [511:0] obs_mem [256];
    int obs_wr = 0;
    int obs_rd = 0;
    int excl_viol = 0;

    bit rdy_rand  = 1'b0;
    bit rdy_force = 1'b1;

    initial begin
        bus.dst_noc_ctd_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.dst_noc_ctd_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    always @(negedge clk) begin
        if (bus.noc_ctd_src_rdy && bus.noc_ctd_dst_val) excl_viol <= excl_viol + 1;
        if (bus.noc_ctd_dst_val && bus.dst_noc_ctd_rdy && obs_wr < 256) begin
            obs_mem[obs_wr] <= bus.noc_ctd_dst_data;
            obs_wr <= obs_wr + 1;
        end
    end

    function automatic logic [511:0] exp_hdr(input logic [63:0] h1, input logic [63:0] h2,
                                             input logic [63:0] e0, input logic [63:0] e1,
                                             input int n);
        logic [511:0] f;
        logic [63:0] a, b;
        a = h1;
        a[29:8] = 22'((n + 7) / 8);
        b = h2;
        b[29:22] = 8'h00;
        f = '0;
        f[511:448] = a;
        f[447:384] = b;
        f[383:320] = e0;
        f[319:288] = e1[63:32];
        return f;
    endfunction

    task automatic send_flit(input logic [63:0] d, input int gap);
        int t;
        if (gap > 0) begin
            repeat ($urandom_range(0, gap)) begin
                @(posedge clk);
                #1;
            end
        end
        bus.src_noc_ctd_val  = 1'b1;
        bus.src_noc_ctd_data = d;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (bus.noc_ctd_src_rdy) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            t++;
            if (t > 2000) begin
                checks++;
                errors++;
                $display("FAIL src_accept_timeout: src_rdy stayed 0, required 1");
                break;
            end
        end
        bus.src_noc_ctd_val  = 1'b0;
        bus.src_noc_ctd_data = '0;
    endtask

    // Sends a message of n payload flits, of which only n_send are actually driven
    task automatic run_msg(input int n, input int gap, input int n_send);
        logic [63:0] h1, h2, e0, e1;
        logic [63:0] p[$];
        logic [511:0] f;
        h1 = {$urandom, $urandom};
        h1[29:8] = 22'(n);
        h2 = {$urandom, $urandom};
        e0 = {$urandom, $urandom};
        e1 = {$urandom, $urandom};
        exp_q.push_back(exp_hdr(h1, h2, e0, e1, n));
        for (int i = 0; i < n; i++) p.push_back({$urandom, $urandom});
        if (n_send == n) begin
            for (int c = 0; c * 8 < n; c++) begin
                f = '0;
                for (int k = 0; k < 8; k++)
                    if (c * 8 + k < n) f[511-64*k -: 64] = p[c*8+k];
                exp_q.push_back(f);
            end
        end
        send_flit(h1, gap);
        send_flit(h2, gap);
        send_flit(e0, gap);
        send_flit(e1, gap);
        for (int i = 0; i < n_send; i++) send_flit(p[i], gap);
    endtask

    task automatic wait_out(input int cnt, input int budget);
        int t;
        t = 0;
        while ((obs_wr - obs_rd) < cnt && t < budget) begin
            @(negedge clk);
            t++;
        end
        if ((obs_wr - obs_rd) < cnt) begin
            checks++;
            errors++;
            $display("FAIL output_timeout: got %0d flits, required %0d", obs_wr - obs_rd, cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.src_noc_ctd_val  = 1'b0;
        bus.src_noc_ctd_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.noc_ctd_dst_val !== 1'b0) begin
            errors++;
            $display("FAIL reset_dst_val: got %b required 0", bus.noc_ctd_dst_val);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.noc_ctd_src_rdy !== 1'b1 || bus.noc_ctd_dst_val !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: src_rdy=%b dst_val=%b required 1/0",
                     bus.noc_ctd_src_rdy, bus.noc_ctd_dst_val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hdr_only();
        logic [511:0] e;
        run_msg(0, 0, 0);
        wait_out(1, 200);
        checks++;
        if (bus.noc_ctd_src_rdy !== 1'b1 || bus.noc_ctd_dst_val !== 1'b0) begin
            errors++;
            $display("FAIL hdr_only_ready_after: src_rdy=%b dst_val=%b required 1/0",
                     bus.noc_ctd_src_rdy, bus.noc_ctd_dst_val);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                errors++;
                $display("FAIL hdr_only_flit: no output, required %h", e);
            end else begin
                if (obs_mem[obs_rd] !== e) begin
                    errors++;
                    $display("FAIL hdr_only_flit: got %h required %h", obs_mem[obs_rd], e);
                end
                obs_rd++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_payload(input int n, input string name);
        logic [511:0] e;
        run_msg(n, 0, n);
        wait_out(exp_q.size(), 500);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                errors++;
                $display("FAIL %s_flit: no output, required %h", name, e);
            end else begin
                if (obs_mem[obs_rd] !== e) begin
                    errors++;
                    $display("FAIL %s_flit: got %h required %h", name, obs_mem[obs_rd], e);
                end
                obs_rd++;
            end
        end
        repeat (10) @(negedge clk);
        checks++;
        if (obs_wr != obs_rd) begin
            errors++;
            $display("FAIL %s_extra_flits: got %0d surplus, required 0", name, obs_wr - obs_rd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        logic [511:0] held, e;
        int t;
        rdy_force = 1'b0;
        fork
            run_msg(8, 0, 8);
            begin
                for (int phase = 0; phase < 2; phase++) begin
                    t = 0;
                    @(negedge clk);
                    while (!bus.noc_ctd_dst_val && t < 500) begin
                        @(negedge clk);
                        t++;
                    end
                    checks++;
                    if (bus.noc_ctd_dst_val !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_wait_val: dst_val=%b required 1", bus.noc_ctd_dst_val);
                    end
                    held = bus.noc_ctd_dst_data;
                    for (int c = 0; c < 5; c++) begin
                        @(negedge clk);
                        checks++;
                        if (bus.noc_ctd_dst_val !== 1'b1 || bus.noc_ctd_src_rdy !== 1'b0 ||
                            bus.noc_ctd_dst_data !== held) begin
                            errors++;
                            $display("FAIL stall_hold: val=%b src_rdy=%b data_changed=%b required 1/0/0",
                                     bus.noc_ctd_dst_val, bus.noc_ctd_src_rdy,
                                     bus.noc_ctd_dst_data !== held);
                        end
                    end
                    @(posedge clk);
                    #1;
                    rdy_force = 1'b1;
                    @(posedge clk);
                    #1;
                    rdy_force = 1'b0;
                end
            end
        join
        rdy_force = 1'b1;
        wait_out(exp_q.size(), 200);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                errors++;
                $display("FAIL stall_flit: no output, required %h", e);
            end else begin
                if (obs_mem[obs_rd] !== e) begin
                    errors++;
                    $display("FAIL stall_flit: got %h required %h", obs_mem[obs_rd], e);
                end
                obs_rd++;
            end
        end
        repeat (10) @(negedge clk);
        checks++;
        if (obs_wr != obs_rd) begin
            errors++;
            $display("FAIL stall_transfer_count: got %0d surplus, required 0", obs_wr - obs_rd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_gaps();
        logic [511:0] e;
        rdy_rand = 1'b1;
        run_msg(10, 3, 10);
        run_msg(0, 2, 0);
        run_msg(5, 3, 5);
        run_msg(16, 2, 16);
        rdy_rand = 1'b0;
        wait_out(exp_q.size(), 2000);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                errors++;
                $display("FAIL gaps_flit: no output, required %h", e);
            end else begin
                if (obs_mem[obs_rd] !== e) begin
                    errors++;
                    $display("FAIL gaps_flit: got %h required %h", obs_mem[obs_rd], e);
                end
                obs_rd++;
            end
        end
        repeat (10) @(negedge clk);
        checks++;
        if (obs_wr != obs_rd) begin
            errors++;
            $display("FAIL gaps_extra_flits: got %0d surplus, required 0", obs_wr - obs_rd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        logic [511:0] e;
        rdy_force = 1'b1;
        run_msg(8, 0, 3);
        wait_out(1, 200);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.noc_ctd_dst_val !== 1'b0 || bus.noc_ctd_src_rdy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_idle: dst_val=%b src_rdy=%b required 0/1",
                     bus.noc_ctd_dst_val, bus.noc_ctd_src_rdy);
        end
        run_msg(0, 0, 0);
        wait_out(exp_q.size(), 200);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                errors++;
                $display("FAIL mid_reset_flit: no output, required %h", e);
            end else begin
                if (obs_mem[obs_rd] !== e) begin
                    errors++;
                    $display("FAIL mid_reset_flit: got %h required %h", obs_mem[obs_rd], e);
                end
                obs_rd++;
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (obs_wr != obs_rd) begin
            errors++;
            $display("FAIL mid_reset_partial_flit: got %0d surplus, required 0", obs_wr - obs_rd);
        end
`ifdef EXTRA_HDR_CTD_STATS_EN
        checks++;
        if (stat_msg_cnt !== 32'd1 || stat_wide_flit_cnt !== 32'd1) begin
            errors++;
            $display("FAIL stats_after_reset: msg=%0d flits=%0d required 1/1",
                     stat_msg_cnt, stat_wide_flit_cnt);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_hdr_only();
        test_payload(8, "single_data");
        test_payload(10, "partial_data");
        test_payload(1, "one_payload");
        test_stall();
        test_gaps();
        test_mid_reset();
        checks++;
        if (excl_viol != 0) begin
            errors++;
            $display("FAIL rdy_val_exclusive: got %0d overlapping cycles, required 0", excl_viol);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
